cell_status_arbiter: RTL and testbench

//  Owns the board cell-status RAM (ROWS x COLS words) and shares its single access port

---
 rtl/cell_status_if.sv | 33 +++
 rtl/cell_status_arbiter.sv | 130 +++++++++++++
 tb/tb_cell_status_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_status_if.sv
// cell_status_if: player/AI request ports, shared read data and board-clear control
// for cell_status_arbiter.
interface cell_status_if #(
    parameter int STATUS_W = 4
) ();
    logic                p_req;
    logic                p_we;
    logic [5:0]          p_addr;
    logic [STATUS_W-1:0] p_wdata;
    logic                p_ack;
    logic                ai_req;
    logic                ai_we;
    logic [5:0]          ai_addr;
    logic [STATUS_W-1:0] ai_wdata;
    logic                ai_ack;
    logic [STATUS_W-1:0] rdata;
    logic                clr_start;
    logic                clr_busy;

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        output ai_req, ai_we, ai_addr, ai_wdata,
        output clr_start,
        input  p_ack, ai_ack, rdata, clr_busy
    );

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        input  ai_req, ai_we, ai_addr, ai_wdata,
        input  clr_start,
        output p_ack, ai_ack, rdata, clr_busy
    );
endinterface

// File: rtl/cell_status_arbiter.sv
// cell_status_arbiter: single-port board cell-status RAM shared by display fetch, clear sweep
// and round-robin player/AI requesters. Define CELL_RMW_OR_EN for OR-accumulating RMW writes.
module cell_status_arbiter #(
    parameter int CELL_W   = 80,
    parameter int CELL_H   = 60,
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int STATUS_W = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                pix_valid,
    output logic [STATUS_W-1:0] disp_status,
    cell_status_if.slave        bus
);

`ifdef CELL_RMW_OR_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic [STATUS_W-1:0] mem [64];
    logic [2:0]          cx, cy;
    logic [5:0]          disp_addr, cache_addr;
    logic                cache_vld;
    logic                clr_busy, clr_last;
    logic [2:0]          clr_row, clr_col;
    logic                rmw_pend, rmw_who;
    logic [5:0]          rmw_addr;
    logic [STATUS_W-1:0] rmw_new, rmw_old;
    logic                ptr;
    logic                disp_go, clr_go, p_el, ai_el, gnt, gnt_ai, gnt_we;
    logic [5:0]          gnt_addr;
    logic [STATUS_W-1:0] gnt_wdata, old_word;

    assign bus.clr_busy = clr_busy;

    // Comparator ladder: the highest boundary passed wins, which also clamps past the grid.
    always_comb begin
        cx = '0;
        cy = '0;
        for (int i = 1; i < COLS; i++) if (int'(pix_x) >= i * CELL_W) cx = 3'(i);
        for (int i = 1; i < ROWS; i++) if (int'(pix_y) >= i * CELL_H) cy = 3'(i);
        disp_addr = {cy, cx};
    end

    always_comb begin
        disp_go   = !rmw_pend && pix_valid && (!cache_vld || disp_addr != cache_addr);
        clr_go    = clr_busy && !rmw_pend && !disp_go;
        p_el      = bus.p_req && !bus.p_ack;
        ai_el     = bus.ai_req && !bus.ai_ack;
        gnt       = !rmw_pend && !disp_go && !clr_busy && !bus.clr_start && (p_el || ai_el);
        gnt_ai    = ai_el && (!p_el || ptr);
        gnt_addr  = gnt_ai ? bus.ai_addr : bus.p_addr;
        gnt_we    = gnt_ai ? bus.ai_we : bus.p_we;
        gnt_wdata = gnt_ai ? bus.ai_wdata : bus.p_wdata;
        old_word  = mem[gnt_addr];
        clr_last  = clr_row == 3'(ROWS - 1) && clr_col == 3'(COLS - 1);
    end

    // Writes are suppressed while reset is asserted so an aborted clear leaves cells intact.
    always_ff @(posedge clk_in) begin
        if (rst_n_in) begin
            if (rmw_pend) mem[rmw_addr] <= rmw_new;
            else if (clr_go) mem[{clr_row, clr_col}] <= '0;
            else if (gnt && gnt_we && !RMW) mem[gnt_addr] <= gnt_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            disp_status <= '0;
            bus.p_ack   <= 1'b0;
            bus.ai_ack  <= 1'b0;
            bus.rdata   <= '0;
            clr_busy    <= 1'b0;
            clr_row     <= '0;
            clr_col     <= '0;
            ptr         <= 1'b0;
            rmw_pend    <= 1'b0;
            rmw_who     <= 1'b0;
            rmw_addr    <= '0;
            rmw_new     <= '0;
            rmw_old     <= '0;
            cache_vld   <= 1'b0;
            cache_addr  <= '0;
        end else begin
            bus.p_ack  <= 1'b0;
            bus.ai_ack <= 1'b0;
            if (disp_go) begin
                disp_status <= mem[disp_addr];
                cache_addr  <= disp_addr;
                cache_vld   <= 1'b1;
            end
            if (bus.clr_start && !clr_busy) begin
                clr_busy <= 1'b1;
                clr_row  <= '0;
                clr_col  <= '0;
            end else if (clr_go) begin
                clr_busy <= !clr_last;
                clr_row  <= clr_col == 3'(COLS - 1) ? clr_row + 3'd1 : clr_row;
                clr_col  <= clr_col == 3'(COLS - 1) ? 3'd0 : clr_col + 3'd1;
            end
            if (rmw_pend) begin
                rmw_pend   <= 1'b0;
                bus.p_ack  <= !rmw_who;
                bus.ai_ack <= rmw_who;
                bus.rdata  <= rmw_old;
            end
            if (gnt) begin
                ptr <= !gnt_ai;
                if (RMW && gnt_we) begin
                    rmw_pend <= 1'b1;
                    rmw_who  <= gnt_ai;
                    rmw_addr <= gnt_addr;
                    rmw_new  <= old_word | gnt_wdata;
                    rmw_old  <= old_word;
                end else begin
                    bus.p_ack  <= !gnt_ai;
                    bus.ai_ack <= gnt_ai;
                    bus.rdata  <= old_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_status_arbiter.sv
// tb_cell_status_arbiter: randomized scoreboard bench for cell_status_arbiter; a board model
// predicts read data at issue time and a monitor checks every ack against it.
module tb_cell_status_arbiter;

`ifdef CELL_RMW_OR_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       pix_valid = 1'b0;
    logic [3:0] disp_status;

    cell_status_if #(.STATUS_W(4)) bus ();

    cell_status_arbiter #(
        .CELL_W(80), .CELL_H(60), .COLS(8), .ROWS(8), .STATUS_W(4)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_valid(pix_valid),
        .disp_status(disp_status),
        .bus(bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int         total = 0;
    int         bad = 0;
    int         ack_in_busy = 0;
    logic [3:0] mdl [64];
    logic [3:0] exp_p [$];
    logic [3:0] exp_ai [$];
    int         order_q [$];

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    function automatic logic [3:0] cell_at(input int x, input int y);
        int c = x / 80;
        int r = y / 60;
        if (c > 7) c = 7;
        if (r > 7) r = 7;
        return mdl[r * 8 + c];
    endfunction

    always @(negedge clk_in) begin
        if (bus.p_ack) begin
            order_q.push_back(0);
            chk("p_ack_held_req", int'(bus.p_req), 1);
            if (bus.clr_busy) ack_in_busy++;
            if (exp_p.size() == 0) begin
                total++;
                bad++;
                $display("FAIL p_ack_unexpected got=ack want=none");
            end else chk("p_rdata", int'(bus.rdata), int'(exp_p.pop_front()));
        end
        if (bus.ai_ack) begin
            order_q.push_back(1);
            chk("ai_ack_held_req", int'(bus.ai_req), 1);
            if (bus.clr_busy) ack_in_busy++;
            if (exp_ai.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ai_ack_unexpected got=ack want=none");
            end else chk("ai_rdata", int'(bus.rdata), int'(exp_ai.pop_front()));
        end
    end

    task automatic txn(input bit who, input bit we, input logic [5:0] a, input logic [3:0] d,
                       output int lat);
        logic [3:0] old = mdl[a];
        if (who) exp_ai.push_back(old);
        else exp_p.push_back(old);
        if (we) mdl[a] = RMW ? (old | d) : d;
        @(posedge clk_in);
        #1;
        if (who) begin
            bus.ai_req = 1'b1; bus.ai_we = we; bus.ai_addr = a; bus.ai_wdata = d;
        end else begin
            bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = a; bus.p_wdata = d;
        end
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (who ? bus.ai_ack : bus.p_ack) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL %s_ack_timeout got=none want=ack", who ? "ai" : "p");
        end
        @(posedge clk_in);
        #1;
        if (who) bus.ai_req = 1'b0;
        else bus.p_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1 rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
    endtask

    int         lat, l1, l2, lat4, n;
    logic [5:0] a1, a2;
    logic [3:0] last_disp;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.ai_req = 0; bus.ai_we = 0; bus.ai_addr = '0; bus.ai_wdata = '0;
        bus.clr_start = 0;
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("rst_disp_status", int'(disp_status), 0);
        chk("rst_p_ack", int'(bus.p_ack), 0);
        chk("rst_ai_ack", int'(bus.ai_ack), 0);
        chk("rst_rdata", int'(bus.rdata), 0);
        chk("rst_clr_busy", int'(bus.clr_busy), 0);

        // Full-board clear with a requester stalled behind it
        fork
            begin
                @(posedge clk_in);
                #1 bus.clr_start = 1'b1;
                @(posedge clk_in);
                #1 bus.clr_start = 1'b0;
                n = 0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk_in);
                    if (!bus.clr_busy) break;
                    n++;
                end
                chk("clr_busy_cycles", n, 64);
            end
            begin
                repeat (6) @(posedge clk_in);
                txn(0, 0, 6'h11, 4'h0, lat);
            end
        join
        chk("ack_during_clear", ack_in_busy, 0);
        for (int i = 0; i < 4; i++) txn(1, 0, 6'($urandom_range(0, 63)), 4'h0, lat);

        // Write then read back the same cell
        txn(0, 1, 6'h09, 4'h3, lat);
        chk("wr_ack_latency", lat, RMW ? 2 : 1);
        txn(0, 0, 6'h09, 4'h0, lat);
        chk("rd_ack_latency", lat, 1);

        // Simultaneous requests alternate starting with the player
        do_reset();
        order_q.delete();
        for (int r = 0; r < 4; r++) begin
            a1 = 6'(32 + 2 * $urandom_range(0, 15));
            a2 = 6'(33 + 2 * $urandom_range(0, 15));
            fork
                txn(0, 1'($urandom_range(0, 1)), a1, 4'($urandom), l1);
                txn(1, 1'($urandom_range(0, 1)), a2, 4'($urandom), l2);
            join
        end
        chk("rr_ack_count", order_q.size(), 8);
        for (int i = 0; i < 8 && i < order_q.size(); i++) chk("rr_order", order_q[i], i % 2);

        // Display sweep across rows 1 and 5 with a requester active mid-line
        txn(0, 1, {3'd1, 3'd2}, 4'h5, lat);
        for (int c = 0; c < 8; c++) begin
            if (c != 2) txn(1, 1, {3'd1, 3'(c)}, 4'($urandom), lat);
            txn(0, 1, {3'd5, 3'(c)}, 4'($urandom), lat);
        end
        fork
            begin
                for (int y = 0; y < 2; y++) begin
                    for (int x = 0; x < 800; x++) begin
                        @(posedge clk_in);
                        #1;
                        pix_valid = 1'b1;
                        pix_x = 10'(x);
                        pix_y = y ? 10'd300 : 10'd70;
                        @(negedge clk_in);
                        if (x % 80 == 2) chk("disp_status", int'(disp_status), int'(cell_at(x, int'(pix_y))));
                    end
                end
                last_disp = cell_at(799, 300);
                @(posedge clk_in);
                #1 pix_valid = 1'b0;
                pix_x = 10'd5;
                pix_y = 10'd5;
                repeat (4) @(negedge clk_in);
                chk("disp_hold_invalid", int'(disp_status), int'(last_disp));
            end
            begin
                repeat (200) @(posedge clk_in);
                txn(0, 0, 6'($urandom_range(0, 63)), 4'h0, lat4);
                chk("sweep_ack_within_3", int'(lat4 <= 3), 1);
                repeat (300) @(posedge clk_in);
                txn(1, 0, 6'($urandom_range(0, 63)), 4'h0, lat4);
                chk("sweep_ai_ack_within_3", int'(lat4 <= 3), 1);
            end
        join

        // OR-accumulate vs plain overwrite on cell 0
        txn(0, 1, 6'h00, 4'h1, lat);
        txn(1, 1, 6'h00, 4'h2, lat);
        txn(0, 0, 6'h00, 4'h0, lat);

        // Reset in the middle of a clear sweep
        for (int i = 5; i < 16; i++) txn(i % 2 == 1, 1, 6'(i), 4'($urandom_range(1, 15)), lat);
        txn(1, 1, 6'd63, 4'hA, lat);
        @(posedge clk_in);
        #1 bus.clr_start = 1'b1;
        @(posedge clk_in);
        #1 bus.clr_start = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("clr_busy_mid", int'(bus.clr_busy), 1);
        @(posedge clk_in);
        #1 rst_n_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_abort_clr_busy", int'(bus.clr_busy), 0);
        chk("rst_abort_p_ack", int'(bus.p_ack), 0);
        chk("rst_abort_ai_ack", int'(bus.ai_ack), 0);
        chk("rst_abort_rdata", int'(bus.rdata), 0);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        for (int i = 0; i < 10; i++) mdl[i] = '0;
        for (int i = 0; i < 16; i++) txn(i % 2 == 0, 0, 6'(i), 4'h0, lat);
        txn(0, 0, 6'd63, 4'h0, lat);

        repeat (5) @(posedge clk_in);
        chk("p_queue_drained", exp_p.size(), 0);
        chk("ai_queue_drained", exp_ai.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
